// File: rtl/ecg_nn_pkg.sv
// Shared sizing for the ECG network datapath and the word-accept
// classification used by the activation loader.
package ecg_nn_pkg;

   localparam int unsigned N_IN        = 15;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned FRAME_CNT_W = 16;

   typedef enum logic [2:0] {
      ACC_IDLE,
      ACC_NEXT,
      ACC_FULL,
      ACC_EARLY,
      ACC_LATE
   } acc_e;

   // Outcome of one input-side cycle given the handshake and frame position.
   function automatic acc_e classify(input logic accept,
                                     input logic last,
                                     input logic at_end);
      acc_e r;
      r = ACC_IDLE;
      if (accept) begin
         if (at_end) r = last ? ACC_FULL : ACC_LATE;
         else        r = last ? ACC_EARLY : ACC_NEXT;
      end
      return r;
   endfunction

endpackage

// File: rtl/act_loader.sv
// Collects a frame of N_IN activation words from a valid/ready stream and
// presents it as one parallel bus with a valid/ack hold handshake.
module act_loader
   import ecg_nn_pkg::*;
#(
   parameter int unsigned N_IN   = ecg_nn_pkg::N_IN,
   parameter int unsigned WORD_W = ecg_nn_pkg::WORD_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [WORD_W-1:0]        s_data,
   input  logic                     s_last,
   output logic [N_IN*WORD_W-1:0]   a_bus,
   output logic                     a_valid,
   input  logic                     a_ack,
   output logic                     err,
   output logic [FRAME_CNT_W-1:0]   frame_cnt
);

   localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

   logic [WORD_W-1:0] fill_buf [N_IN];
   logic [WORD_W-1:0] out_reg  [N_IN];
   logic [IDX_W-1:0]  wr_idx;
   logic              full;
   logic              accept;
   logic              xfer;
   acc_e              acc;

   assign s_ready = ~full;
   assign accept  = s_valid & ~full;
   assign xfer    = full & (~a_valid | a_ack);
   assign acc     = classify(accept, s_last, wr_idx == IDX_W'(N_IN - 1));

   always_comb begin
      a_bus = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         a_bus[i*WORD_W +: WORD_W] = out_reg[i];
      end
   end

   // Fill storage carries no reset: 'full' and wr_idx gate its visibility.
   always_ff @(posedge clk) begin
      if (accept) begin
         fill_buf[wr_idx] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_IN; i++) begin
            out_reg[i] <= '0;
         end
         wr_idx    <= '0;
         full      <= 1'b0;
         a_valid   <= 1'b0;
         err       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         err <= 1'b0;

         unique case (acc)
            ACC_NEXT: wr_idx <= wr_idx + IDX_W'(1);
            ACC_FULL: begin
               wr_idx <= '0;
               full   <= 1'b1;
            end
            ACC_EARLY, ACC_LATE: begin
               wr_idx <= '0;
               err    <= 1'b1;
            end
            default: ;
         endcase

         // accept needs !full and xfer needs full, so they never collide.
         if (xfer) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
               out_reg[i] <= fill_buf[i];
            end
            a_valid   <= 1'b1;
            full      <= 1'b0;
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
         end else if (a_ack && a_valid) begin
            a_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_act_loader.sv
// Directed bench for act_loader: framing, hold handshake, errors, reset, wrap.
module tb_act_loader;
   import ecg_nn_pkg::*;

   localparam int unsigned NW = 15;
   localparam int unsigned WW = 32;
   localparam int unsigned BW = NW * WW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [WW-1:0] s_data;
   logic          s_last;
   logic [BW-1:0] a_bus;
   logic          a_valid;
   logic          a_ack;
   logic          err;
   logic [15:0]   frame_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   act_loader #(.N_IN(NW), .WORD_W(WW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .a_bus     (a_bus),
      .a_valid   (a_valid),
      .a_ack     (a_ack),
      .err       (err),
      .frame_cnt (frame_cnt)
   );

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] frame(input logic [WW-1:0] base);
      logic [BW-1:0] v;
      v = '0;
      for (int i = 0; i < NW; i++) v[i*WW +: WW] = base + WW'(i);
      return v;
   endfunction

   task automatic send_word(input logic [WW-1:0] d, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (!s_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $error("FAIL s_ready_timeout: observed 0 expected 1");
      end
      @(posedge clk);
   endtask

   task automatic send_frame(input logic [WW-1:0] base, input int n_words, input int last_idx);
      for (int i = 0; i < n_words; i++) send_word(base + WW'(i), i == last_idx);
   endtask

   task automatic idle();
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Clean frame then: one edge to fill, one edge to present.
   task automatic expect_frame(input string tag, input logic [WW-1:0] base, input logic [15:0] cnt);
      send_frame(base, NW, NW - 1);
      idle();
      chk({tag, "_valid_before"}, a_valid, 1'b0);
      @(negedge clk);
      chk({tag, "_valid"}, a_valid, 1'b1);
      chk({tag, "_bus"}, a_bus, frame(base));
      chk({tag, "_cnt"}, frame_cnt, cnt);
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      a_ack   = 1'b0;
      #12;
      chk("rst_bus", a_bus, '0);
      chk("rst_valid", a_valid, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_cnt", frame_cnt, 16'd0);
      chk("rst_ready", s_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      send_frame(32'h3F80_0000, NW, NW - 1);
      idle();
      chk("a_full_valid", a_valid, 1'b0);
      chk("a_full_ready", s_ready, 1'b0);
      @(negedge clk);
      chk("a_valid", a_valid, 1'b1);
      chk("a_bus", a_bus, frame(32'h3F80_0000));
      chk("a_cnt", frame_cnt, 16'd1);
      chk("a_ready", s_ready, 1'b1);

      send_frame(32'h4000_0000, NW, NW - 1);
      idle();
      chk("b_wait_ready", s_ready, 1'b0);
      chk("b_wait_bus", a_bus, frame(32'h3F80_0000));
      @(negedge clk);
      chk("b_hold_bus", a_bus, frame(32'h3F80_0000));
      chk("b_hold_valid", a_valid, 1'b1);
      chk("b_hold_cnt", frame_cnt, 16'd1);
      a_ack = 1'b1;
      @(negedge clk);
      a_ack = 1'b0;
      chk("b_valid", a_valid, 1'b1);
      chk("b_bus", a_bus, frame(32'h4000_0000));
      chk("b_cnt", frame_cnt, 16'd2);
      chk("b_ready", s_ready, 1'b1);

      a_ack = 1'b1;
      @(negedge clk);
      a_ack = 1'b0;
      chk("ack_clear", a_valid, 1'b0);
      a_ack = 1'b1;
      @(negedge clk);
      a_ack = 1'b0;
      chk("ack_idle_valid", a_valid, 1'b0);
      chk("ack_idle_cnt", frame_cnt, 16'd2);

      send_frame(32'h1111_0000, 6, 5);
      idle();
      chk("early_err", err, 1'b1);
      chk("early_valid", a_valid, 1'b0);
      chk("early_ready", s_ready, 1'b1);
      @(negedge clk);
      chk("early_err_clr", err, 1'b0);
      expect_frame("c", 32'hC000_0000, 16'd3);

      send_frame(32'h2222_0000, NW, -1);
      idle();
      chk("late_err", err, 1'b1);
      @(negedge clk);
      chk("late_err_clr", err, 1'b0);
      chk("late_valid", a_valid, 1'b1);
      chk("late_bus", a_bus, frame(32'hC000_0000));
      chk("late_cnt", frame_cnt, 16'd3);
      chk("late_ready", s_ready, 1'b1);

      send_frame(32'h3333_0000, 7, -1);
      @(negedge clk);
      s_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk("mrst_bus", a_bus, '0);
      chk("mrst_valid", a_valid, 1'b0);
      chk("mrst_cnt", frame_cnt, 16'd0);
      chk("mrst_ready", s_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", a_valid, 1'b0);
      chk("post_rst_err", err, 1'b0);
      expect_frame("d", 32'h4444_0000, 16'd1);

      a_ack = 1'b1;
      expect_frame("e", 32'h5555_0000, 16'd2);
      @(negedge clk);
      force dut.frame_cnt = 16'hFFFE;
      #1;
      release dut.frame_cnt;
      chk("preload_cnt", frame_cnt, 16'hFFFE);
      expect_frame("f", 32'h6666_0000, 16'hFFFF);
      expect_frame("g", 32'h7777_0000, 16'h0000);
      a_ack = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
